// File: rtl/wire_mult_engine_if.sv
// Purpose : host-facing wire/trigger bundle for the shift-add multiply engine.
// Latency : n/a (signal bundle only).
// Backpressure: none; wire-ins are levels, start/done_trig are single-cycle triggers.
// Ports   : op_a/op_b/op_mode/start driven by the host (master),
//           result_lo/result_hi/status/done_trig driven by the engine (slave).
interface wire_mult_engine_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_mode;
  logic             start;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [31:0]      status;
  logic             done_trig;

  modport master (
    output op_a, op_b, op_mode, start,
    input  result_lo, result_hi, status, done_trig
  );

  modport slave (
    input  op_a, op_b, op_mode, start,
    output result_lo, result_hi, status, done_trig
  );
endinterface

// File: rtl/wire_mult_engine.sv
// Purpose : unsigned shift-add multiplier / multiply-accumulator behind wire-in/out endpoints.
// Latency : start at edge t -> done_trig in cycle t+WIDTH+1 (clear/reserved ops: cycle t+1).
// Backpressure: none; a start while busy is dropped and flagged in status.error.
// Ports   : okClk (clock), reset (sync, active-high), bus (slave modport):
//           op_a/op_b/op_mode/start in; result_lo/result_hi/status/done_trig out, all registered.
module wire_mult_engine #(
  parameter int WIDTH   = 32,
  parameter int ACC_SAT = 0
) (
  input  logic                okClk,
  input  logic                reset,
  wire_mult_engine_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_MUL = 2'b00;
  localparam logic [1:0] MODE_MAC = 2'b01;
  localparam logic [1:0] MODE_CLR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // op_a, shifted left one place per step
  logic [WIDTH-1:0]   mplier_q, mplier_d; // op_b, consumed LSB first
  logic [2*WIDTH-1:0] prod_q, prod_d;     // running partial product
  logic [CW-1:0]      step_q, step_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [7:0]         opcnt_q, opcnt_d;
  logic               trig_q, trig_d;

  logic [2*WIDTH:0]   mac_sum;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    step_d   = step_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    done_d   = done_q;
    opcnt_d  = opcnt_q;
    trig_d   = 1'b0;
    mac_sum  = {1'b0, acc_q} + {1'b0, prod_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.op_mode;
          done_d = 1'b0;
          // Clear and reserved ops take effect on this edge and then spend
          // one cycle in DONE so their trigger lands one cycle later.
          state_d = DONE;
          case (bus.op_mode)
            MODE_MUL, MODE_MAC: begin
              mcand_d  = {{WIDTH{1'b0}}, bus.op_a};
              mplier_d = bus.op_b;
              prod_d   = '0;
              step_d   = '0;
              state_d  = RUN;
            end
            MODE_CLR: begin
              acc_d = '0;
              ovf_d = 1'b0;
              err_d = 1'b0;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      RUN: begin
        if (bus.start) begin
          err_d = 1'b1;
        end
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.start) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
        trig_d  = 1'b1;
        done_d  = 1'b1;
        case (op_q)
          MODE_MUL: begin
            acc_d   = prod_q;
            opcnt_d = opcnt_q + 8'd1;
          end
          MODE_MAC: begin
            opcnt_d = opcnt_q + 8'd1;
            if (mac_sum[2*WIDTH]) begin
              ovf_d = 1'b1;
              acc_d = (ACC_SAT != 0) ? {(2*WIDTH){1'b1}} : mac_sum[2*WIDTH-1:0];
            end else begin
              acc_d = mac_sum[2*WIDTH-1:0];
            end
          end
          MODE_CLR: begin
            opcnt_d = opcnt_q + 8'd1;
          end
          default: begin
            // reserved op: error already recorded, count unchanged
          end
        endcase
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      opcnt_q  <= '0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
      opcnt_q  <= opcnt_d;
      trig_q   <= trig_d;
    end
  end

  // Every output is a flop or a decode of the state flop only.
  assign bus.result_lo = acc_q[WIDTH-1:0];
  assign bus.result_hi = acc_q[2*WIDTH-1:WIDTH];
  assign bus.done_trig = trig_q;
  assign bus.status    = {16'h0000, opcnt_q, 4'h0, err_q, ovf_q, done_q, (state_q != IDLE)};

endmodule

// File: tb/tb_wire_mult_engine.sv
// Purpose : self-checking bench for wire_mult_engine (WIDTH=32, ACC_SAT=0).
// Latency : expects done_trig 33 cycles after a multiply start, 1 cycle after clear/reserved.
// Backpressure: none; starts are only issued from idle except where a busy start is intended.
module tb_wire_mult_engine;

  localparam int W   = 32;
  localparam int SAT = 0;

  logic okClk = 1'b0;
  logic reset;

  wire_mult_engine_if #(.WIDTH(W)) bus ();

  wire_mult_engine #(.WIDTH(W), .ACC_SAT(SAT)) dut (
    .okClk (okClk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 okClk = ~okClk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state only, updated with plain arithmetic.
  logic [63:0] acc_m;
  logic        ovf_m, err_m, done_m;
  logic [7:0]  cnt_m;

  task automatic model_reset();
    acc_m = '0; ovf_m = 1'b0; err_m = 1'b0; done_m = 1'b0; cnt_m = '0;
  endtask

  task automatic model_op(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [64:0] s;
    p = 64'(a) * 64'(b);
    case (mode)
      2'd0: begin acc_m = p; cnt_m = cnt_m + 8'd1; end
      2'd1: begin
        s = 65'(acc_m) + 65'(p);
        if (s > 65'h0_FFFF_FFFF_FFFF_FFFF) begin
          ovf_m = 1'b1;
          acc_m = (SAT != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
        end else begin
          acc_m = s[63:0];
        end
        cnt_m = cnt_m + 8'd1;
      end
      2'd2: begin acc_m = '0; ovf_m = 1'b0; err_m = 1'b0; cnt_m = cnt_m + 8'd1; end
      default: err_m = 1'b1;
    endcase
    done_m = 1'b1;
  endtask

  function automatic logic [31:0] exp_status();
    return {16'h0000, cnt_m, 4'h0, err_m, ovf_m, done_m, 1'b0};
  endfunction

  task automatic issue(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b);
    @(negedge okClk);
    bus.op_mode = mode; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    @(negedge okClk);
    bus.start   = 1'b0;
    // Scramble the wire-ins: the engine must have captured them already.
    bus.op_a    = $urandom;
    bus.op_b    = $urandom;
    bus.op_mode = 2'($urandom_range(0, 3));
  endtask

  // Waits for done_trig; reports its latency (-1 if never seen), the outputs
  // in the trigger cycle, and whether the trigger was still high a cycle later.
  task automatic wait_done(output int lat, output bit second, output logic [31:0] lo,
                           output logic [31:0] hi, output logic [31:0] st);
    lat = -1; second = 1'b0; lo = '0; hi = '0; st = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge okClk); #1;
      if (bus.done_trig === 1'b1) begin
        lat = i; lo = bus.result_lo; hi = bus.result_hi; st = bus.status;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge okClk); #1;
      second = (bus.done_trig === 1'b1);
    end
  endtask

  task automatic pulse_reset();
    @(negedge okClk); reset = 1'b1;
    @(negedge okClk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.op_mode = 2'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
    model_reset();
    repeat (3) @(posedge okClk);
    #1;
    checks++; if (bus.result_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.result_hi); end
    checks++; if (bus.status !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", bus.status); end
    checks++; if (bus.done_trig !== 1'b0) begin errors++; $display("FAIL reset_trig got=%b exp=0", bus.done_trig); end
    @(negedge okClk); reset = 1'b0; bus.start = 1'b0;
    @(posedge okClk); #1;
    checks++; if (bus.status !== 32'h0) begin errors++; $display("FAIL reset_override_start status got=%h exp=0", bus.status); end
  endtask

  task automatic test_basic_mul();
    int lat; bit second; logic [31:0] lo, hi, st;
    issue(2'd0, 32'd3, 32'd5);
    model_op(2'd0, 32'd3, 32'd5);
    wait_done(lat, second, lo, hi, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL basic_latency got=%0d exp=33", lat); end
    checks++; if (lo !== 32'h0000_000F) begin errors++; $display("FAIL basic_lo got=%h exp=0000000f", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL basic_hi got=%h exp=0", hi); end
    checks++; if (st !== 32'h0000_0102) begin errors++; $display("FAIL basic_status got=%h exp=00000102", st); end
    checks++; if (second !== 1'b0) begin errors++; $display("FAIL basic_trig_width got=2 cycles exp=1"); end
  endtask

  task automatic test_max_and_overflow();
    int lat; bit second; logic [31:0] lo, hi, st;
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    model_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, second, lo, hi, st);
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL max_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL max_lo got=%h exp=00000001", lo); end
    checks++; if (st[2] !== 1'b0) begin errors++; $display("FAIL max_overflow got=%b exp=0", st[2]); end

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    model_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, second, lo, hi, st);
    checks++; if (hi !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ovf_hi got=%h exp=fffffffc", hi); end
    checks++; if (lo !== 32'h0000_0002) begin errors++; $display("FAIL ovf_lo got=%h exp=00000002", lo); end
    checks++; if (st[2] !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", st[2]); end

    issue(2'd2, 32'h0, 32'h0);
    model_op(2'd2, 32'h0, 32'h0);
    wait_done(lat, second, lo, hi, st);
    checks++; if (lat !== 1) begin errors++; $display("FAIL clear_latency got=%0d exp=1", lat); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL clear_acc got=%h exp=0", {hi, lo}); end
    checks++; if (st !== exp_status()) begin errors++; $display("FAIL clear_status got=%h exp=%h", st, exp_status()); end
  endtask

  task automatic test_mac();
    int lat; bit second; logic [31:0] lo, hi, st;
    pulse_reset();
    issue(2'd0, 32'd2, 32'd3);
    model_op(2'd0, 32'd2, 32'd3);
    wait_done(lat, second, lo, hi, st);
    issue(2'd1, 32'd4, 32'd5);
    model_op(2'd1, 32'd4, 32'd5);
    wait_done(lat, second, lo, hi, st);
    checks++; if (lo !== 32'h0000_001A) begin errors++; $display("FAIL mac_lo got=%h exp=0000001a", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mac_hi got=%h exp=0", hi); end
    checks++; if (st[15:8] !== 8'd2) begin errors++; $display("FAIL mac_opcount got=%0d exp=2", st[15:8]); end
  endtask

  task automatic test_reserved();
    int lat; bit second; logic [31:0] lo, hi, st;
    issue(2'd3, 32'h1234, 32'h5678);
    model_op(2'd3, 32'h1234, 32'h5678);
    wait_done(lat, second, lo, hi, st);
    checks++; if (lat !== 1) begin errors++; $display("FAIL reserved_latency got=%0d exp=1", lat); end
    checks++; if ({hi, lo} !== acc_m) begin errors++; $display("FAIL reserved_acc got=%h exp=%h", {hi, lo}, acc_m); end
    checks++; if (st[3] !== 1'b1) begin errors++; $display("FAIL reserved_error got=%b exp=1", st[3]); end
    checks++; if (st[15:8] !== cnt_m) begin errors++; $display("FAIL reserved_opcount got=%0d exp=%0d", st[15:8], cnt_m); end
  endtask

  task automatic test_start_in_run();
    logic [31:0] a, b, lo, hi, st;
    int first, ntrig;
    a = $urandom; b = $urandom;
    issue(2'd0, a, b);
    model_op(2'd0, a, b);
    err_m = 1'b1;
    first = -1; ntrig = 0; lo = '0; hi = '0; st = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge okClk); #1;
      if (i == 5) begin
        bus.op_mode = 2'd2; bus.op_a = 32'h1; bus.op_b = 32'h1; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done_trig === 1'b1) begin
        ntrig++;
        if (first < 0) begin
          first = i; lo = bus.result_lo; hi = bus.result_hi; st = bus.status;
        end
      end
    end
    checks++; if (first !== 33) begin errors++; $display("FAIL busy_start_latency got=%0d exp=33", first); end
    checks++; if (ntrig !== 1) begin errors++; $display("FAIL busy_start_trig_count got=%0d exp=1", ntrig); end
    checks++; if ({hi, lo} !== acc_m) begin errors++; $display("FAIL busy_start_result got=%h exp=%h", {hi, lo}, acc_m); end
    checks++; if (st !== exp_status()) begin errors++; $display("FAIL busy_start_status got=%h exp=%h", st, exp_status()); end
  endtask

  task automatic test_reset_in_run();
    int ntrig;
    issue(2'd0, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (10) @(posedge okClk);
    #1; reset = 1'b1;
    @(posedge okClk); #1;
    reset = 1'b0;
    model_reset();
    checks++; if (bus.status !== 32'h0) begin errors++; $display("FAIL abort_status got=%h exp=0", bus.status); end
    checks++; if ({bus.result_hi, bus.result_lo} !== 64'h0) begin errors++; $display("FAIL abort_result got=%h exp=0", {bus.result_hi, bus.result_lo}); end
    ntrig = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_trig === 1'b1) ntrig++;
      @(posedge okClk); #1;
    end
    checks++; if (ntrig !== 0) begin errors++; $display("FAIL abort_no_trig got=%0d exp=0", ntrig); end
  endtask

  task automatic test_random();
    int lat, exp_lat; bit second; logic [31:0] a, b, lo, hi, st;
    logic [1:0] mode;
    int r;
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      mode = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      issue(mode, a, b);
      model_op(mode, a, b);
      exp_lat = (mode[1] == 1'b0) ? 33 : 1;
      wait_done(lat, second, lo, hi, st);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency mode=%0d got=%0d exp=%0d", n, mode, lat, exp_lat); end
      checks++; if ({hi, lo} !== acc_m) begin errors++; $display("FAIL rand%0d_result mode=%0d got=%h exp=%h", n, mode, {hi, lo}, acc_m); end
      checks++; if (st !== exp_status()) begin errors++; $display("FAIL rand%0d_status got=%h exp=%h", n, st, exp_status()); end
      checks++; if (second !== 1'b0) begin errors++; $display("FAIL rand%0d_trig_width got=2 cycles exp=1", n); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_mul();
    test_max_and_overflow();
    test_mac();
    test_reserved();
    test_start_in_run();
    test_reset_in_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wire_mult_engine.md
WIRE_MULT_ENGINE -- requirements
Module: wire_mult_engine

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; the accumulator is 2*WIDTH bits.
REQ-002 Parameter ACC_SAT, default 0; 0 = accumulator wraps on overflow, 1 = accumulator saturates to all ones.
REQ-003 Port okClk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port op_a, input, WIDTH bits: unsigned operand A, driven from a wire-in endpoint.
REQ-006 Port op_b, input, WIDTH bits: unsigned operand B, driven from a wire-in endpoint.
REQ-007 Port op_mode, input, 2 bits: 00 multiply, 01 multiply-accumulate, 10 clear, 11 reserved.
REQ-008 Port start, input, 1 bit: single-cycle trigger-in pulse requesting an operation.
REQ-009 Port result_lo, output, WIDTH bits: accumulator bits [WIDTH-1:0], feeding a wire-out endpoint.
REQ-010 Port result_hi, output, WIDTH bits: accumulator bits [2*WIDTH-1:WIDTH], feeding a wire-out endpoint.
REQ-011 Port status, output, 32 bits: bit0 busy, bit1 done, bit2 overflow, bit3 error, [15:8] op_count, all other bits 0.
REQ-012 Port done_trig, output, 1 bit: single-cycle pulse for a trigger-out endpoint.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; reset state is IDLE.
REQ-014 In IDLE with start=1 and op_mode 00/01: op_a, op_b and op_mode captured on that edge; done cleared; next state RUN.
REQ-015 RUN SHALL perform shift-add multiplication, one op_b bit per cycle LSB first, for exactly WIDTH cycles; op_a/op_b changes during RUN have no effect.
REQ-016 After the last RUN cycle, DONE SHALL last 1 cycle: accumulator updated, done_trig=1, done=1, op_count incremented modulo 256; next state IDLE.
REQ-017 Latency: start at edge t -> done_trig high in cycle t+WIDTH+1; result_lo/hi valid in that cycle.
REQ-018 Mode 00: accumulator = op_a*op_b (full 2*WIDTH product, never overflows).
REQ-019 Mode 01: accumulator = accumulator + op_a*op_b in 2*WIDTH+1 bits; a carry-out sets overflow, and the result is the low 2*WIDTH bits (ACC_SAT=0) or all ones (ACC_SAT=1).
REQ-020 Mode 10 start in IDLE: accumulator, overflow, error cleared next edge; done_trig pulses 1 cycle later; done=1; op_count incremented; no RUN.
REQ-021 Mode 11 start in IDLE: error set; accumulator unchanged; done_trig pulses 1 cycle later; op_count unchanged.
REQ-022 start while in RUN or DONE SHALL be ignored and SHALL set error; the in-flight operation is unaffected.
REQ-023 busy=1 in RUN and DONE, 0 in IDLE.
REQ-024 overflow and error are sticky; cleared only by mode 10 or reset.
REQ-025 done_trig SHALL never be high for two consecutive cycles.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 reset=1 at any edge SHALL force IDLE, accumulator=0, result_lo=result_hi=0, status=0, done_trig=0.
REQ-028 reset SHALL override start in the same cycle.
REQ-029 reset during RUN/DONE SHALL abort the operation; no done_trig is produced for the aborted operation.

Verification (WIDTH=32)
REQ-030 Reset; mode 00, a=3, b=5, start -> done_trig exactly 33 cycles later; lo=0x0000000F, hi=0, status=0x00000102.
REQ-031 Mode 00, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, overflow=0.
REQ-032 Mode 00 a=2,b=3, then mode 01 a=4,b=5 -> lo=0x0000001A, hi=0, op_count=2.
REQ-033 After REQ-031, mode 01 a=b=0xFFFFFFFF -> ACC_SAT=0: hi=0xFFFFFFFC, lo=0x00000002, status bit2=1; ACC_SAT=1: hi=lo=0xFFFFFFFF; subsequent mode 10 clears accumulator and bit2.
REQ-034 start pulsed 5 cycles into RUN -> ignored, error=1, first result correct, exactly one done_trig.
REQ-035 reset asserted 10 cycles into RUN -> next cycle busy=0, all outputs 0, no done_trig within 40 cycles.
